pi_accumulator: RTL

Downstream stage of the incremental (velocity-form) PI path. It consumes the signed per-sample control increment delta_u and integrates it into the absolute actuator command u_out (u[k] = u[k-1] + delta_u[k]). The sum is clamped to configurable limits, which gives anti-windup. Valid/ready handshakes sit on both sides, and a preset port supports bumpless initialisation.

---
 rtl/pi_pkg.sv | 27 ++
 rtl/pi_sat_clamp.sv | 37 +++
 rtl/pi_accumulator.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pi_pkg
// Purpose  : Shared defaults, FSM state encoding and helpers for the
//            velocity-form PI accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package pi_pkg;

    localparam int IN_W_DEF   = 16;
    localparam int OUT_W_DEF  = 16;
    localparam int U_MAX_DEF  = 32767;
    localparam int U_MIN_DEF  = -32768;
    localparam int SAT_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } pi_state_e;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pi_sat_clamp.sv
`default_nettype none
// ============================================================================
// Module   : pi_sat_clamp
// Purpose  : Combinational clamp of a wide signed sum into [U_MIN, U_MAX].
// Ports    : i_sum     - signed input, SUM_W bits
//            o_clamped - clamped result, OUT_W bits
//            o_hi/o_lo - input was above U_MAX / below U_MIN
// Revision : 1.0 - initial release
// ============================================================================
module pi_sat_clamp #(
    parameter int SUM_W = 17,
    parameter int OUT_W = 16,
    parameter int U_MAX = 32767,
    parameter int U_MIN = -32768
) (
    input  logic signed [SUM_W-1:0] i_sum,
    output logic        [OUT_W-1:0] o_clamped,
    output logic                    o_hi,
    output logic                    o_lo
);

    localparam logic signed [SUM_W-1:0] c_max = SUM_W'(U_MAX);
    localparam logic signed [SUM_W-1:0] c_min = SUM_W'(U_MIN);

    always_comb begin
        o_hi      = (i_sum > c_max);
        o_lo      = (i_sum < c_min);
        o_clamped = i_sum[OUT_W-1:0];
        if (o_hi) begin
            o_clamped = c_max[OUT_W-1:0];
        end else if (o_lo) begin
            o_clamped = c_min[OUT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pi_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : pi_accumulator
// Purpose  : Integrates signed per-sample increments into an absolute,
//            clamped actuator command (u[k] = u[k-1] + delta_u[k]).
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            en                       - enables acceptance of new deltas
//            delta_u/in_valid/in_ready- increment input handshake
//            preset_valid/value/ready - bumpless load of the accumulator
//            u_out/out_valid/out_ready- result handshake
//            sat_hi/sat_lo            - last update clamped high / low
//            sat_count                - saturating count of clamp events
// Revision : 1.0 - initial release
// ============================================================================
module pi_accumulator
    import pi_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int U_MAX  = U_MAX_DEF,
    parameter int U_MIN  = U_MIN_DEF,
    parameter int U_INIT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IN_W-1:0]      delta_u,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 preset_valid,
    input  logic [OUT_W-1:0]     preset_value,
    output logic                 preset_ready,
    output logic [OUT_W-1:0]     u_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sat_hi,
    output logic                 sat_lo,
    output logic [SAT_CNT_W-1:0] sat_count
);

    // One extra bit over the wider operand so the sum can never wrap.
    localparam int SUM_W = max_w(IN_W, OUT_W) + 1;

    localparam logic [1:0] c_st_idle = IDLE;
    localparam logic [1:0] c_st_calc = CALC;
    localparam logic [1:0] c_st_out  = OUT;

    generate
        if ((U_MIN >= U_MAX) || (U_INIT < U_MIN) || (U_INIT > U_MAX)) begin : g_param_check
            $error("pi_accumulator: clamp limits or U_INIT out of range");
        end
    endgenerate

    logic [1:0]           r_state;
    logic [IN_W-1:0]      r_delta;
    logic [OUT_W-1:0]     r_u;
    logic                 r_sat_hi;
    logic                 r_sat_lo;
    logic [SAT_CNT_W-1:0] r_sat_cnt;

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_pre_ext;
    logic [OUT_W-1:0]        w_sum_clamped;
    logic                    w_sum_hi;
    logic                    w_sum_lo;
    logic [OUT_W-1:0]        w_pre_clamped;
    logic                    w_pre_hi;
    logic                    w_pre_lo;
    logic [1:0]              w_unused_pre_flags;
    logic                    w_in_ready;

    assign w_sum = $signed({{(SUM_W-OUT_W){r_u[OUT_W-1]}}, r_u})
                 + $signed({{(SUM_W-IN_W){r_delta[IN_W-1]}}, r_delta});

    assign w_pre_ext = $signed({{(SUM_W-OUT_W){preset_value[OUT_W-1]}}, preset_value});

    pi_sat_clamp #(
        .SUM_W (SUM_W),
        .OUT_W (OUT_W),
        .U_MAX (U_MAX),
        .U_MIN (U_MIN)
    ) u_sum_clamp (
        .i_sum     (w_sum),
        .o_clamped (w_sum_clamped),
        .o_hi      (w_sum_hi),
        .o_lo      (w_sum_lo)
    );

    // The preset is clamped like any update, but it never counts as a
    // saturation event, so its flags are discarded.
    pi_sat_clamp #(
        .SUM_W (SUM_W),
        .OUT_W (OUT_W),
        .U_MAX (U_MAX),
        .U_MIN (U_MIN)
    ) u_pre_clamp (
        .i_sum     (w_pre_ext),
        .o_clamped (w_pre_clamped),
        .o_hi      (w_pre_hi),
        .o_lo      (w_pre_lo)
    );

    assign w_unused_pre_flags = {w_pre_hi, w_pre_lo};

    // A pending preset takes priority over a delta in the same cycle.
    assign w_in_ready = (r_state == c_st_idle) && en && !preset_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_delta   <= '0;
            r_u       <= OUT_W'(U_INIT);
            r_sat_hi  <= 1'b0;
            r_sat_lo  <= 1'b0;
            r_sat_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (preset_valid) begin
                        r_u       <= w_pre_clamped;
                        r_sat_hi  <= 1'b0;
                        r_sat_lo  <= 1'b0;
                        r_sat_cnt <= '0;
                    end else if (in_valid && w_in_ready) begin
                        r_delta <= delta_u;
                        r_state <= c_st_calc;
                    end
                end
                c_st_calc: begin
                    r_u      <= w_sum_clamped;
                    r_sat_hi <= w_sum_hi;
                    r_sat_lo <= w_sum_lo;
                    if ((w_sum_hi || w_sum_lo) && (r_sat_cnt != {SAT_CNT_W{1'b1}})) begin
                        r_sat_cnt <= r_sat_cnt + 1'b1;
                    end
                    r_state <= c_st_out;
                end
                c_st_out: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign preset_ready = (r_state == c_st_idle);
    assign out_valid    = (r_state == c_st_out);
    assign u_out        = r_u;
    assign sat_hi       = r_sat_hi;
    assign sat_lo       = r_sat_lo;
    assign sat_count    = r_sat_cnt;

endmodule
`default_nettype wire
